mem_line_master: RTL and testbench

- Initiator side of the 128-bit line interface to slow_memory (mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready).
- Sits between a cache controller (I or D) and slow memory.
- Accepts one miss-service command: optional dirty-victim writeback, then optional line fill.
- Sequences the memory handshakes and returns the fill line to the cache.

---
 rtl/mem_line_master.sv | 180 ++++++++++++++++++
 tb/tb_mem_line_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_master.sv
// Line-interface initiator: optional victim writeback, then optional fill.
// Drives slow_memory strobes and returns the fill line to the cache.
module mem_line_master #(
  parameter int ADDR_W   = 28,
  parameter int LINE_W   = 128,
  parameter int MAX_WAIT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dirty,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [LINE_W-1:0] req_wb_data,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic              err_timeout,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, WB, GAP, RD, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;
  logic              err_q, err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fill_q, fill_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;

  logic strobe, hit, expire;

  // mem_ready only counts while one of our strobes is actually up
  assign strobe = mem_read_q | mem_write_q;
  assign hit    = strobe & mem_ready;
  assign expire = strobe & ~mem_ready & (cnt_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    req_ready_d  = (state_q == IDLE);
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    err_d        = err_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    fill_addr_d  = fill_addr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          fill_d      = req_fill;
          fill_addr_d = req_fill_addr;
          cnt_d       = '0;
          if (req_dirty) begin
            state_d     = WB;
            mem_addr_d  = req_wb_addr;
            mem_wdata_d = req_wb_data;
          end else if (req_fill) begin
            state_d    = RD;
            mem_addr_d = req_fill_addr;
          end else begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end
        end
      end
      WB: begin
        if (!mem_write_q) begin
          mem_write_d = 1'b1;
        end else if (hit) begin
          mem_write_d = 1'b0;
          if (fill_q) begin
            state_d    = GAP;
            mem_addr_d = fill_addr_q;
          end else begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end
        end else if (expire) begin
          mem_write_d  = 1'b0;
          err_d        = 1'b1;
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // read strobe is raised leaving GAP so the gap is exactly one cycle
      GAP: begin
        state_d    = RD;
        mem_read_d = 1'b1;
        cnt_d      = '0;
      end
      RD: begin
        if (!mem_read_q) begin
          mem_read_d = 1'b1;
        end else if (hit) begin
          mem_read_d   = 1'b0;
          resp_data_d  = mem_rdata;
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end else if (expire) begin
          mem_read_d   = 1'b0;
          err_d        = 1'b1;
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cnt_q        <= '0;
      fill_q       <= 1'b0;
      fill_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      fill_addr_q  <= fill_addr_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign err_timeout = err_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_line_master.sv
// Bench for mem_line_master: directed table, hand sequences, random
// commands checked against a latency/result model of the command.
module tb_mem_line_master;

  localparam int MAXW = 8;

  localparam logic [127:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2  = 128'h22220002_22220002_22220002_22220002;
  localparam logic [127:0] D3  = 128'h33330003_33330003_33330003_33330003;
  localparam logic [127:0] D4  = 128'h44440004_44440004_44440004_44440004;
  localparam logic [127:0] D5  = 128'h55550005_55550005_55550005_55550005;
  localparam logic [127:0] D6  = 128'h66660006_66660006_66660006_66660006;
  localparam logic [127:0] D7  = 128'h77770007_77770007_77770007_77770007;
  localparam logic [127:0] D8  = 128'h88880008_88880008_88880008_88880008;
  localparam logic [127:0] D9  = 128'h99990009_99990009_99990009_99990009;
  localparam logic [127:0] D10 = 128'hAAAA000A_AAAA000A_AAAA000A_AAAA000A;

  typedef struct {
    bit           dirty;
    bit           fill;
    logic [27:0]  wa;
    logic [127:0] wd;
    logic [27:0]  fa;
    logic [127:0] rd;
    int           nw;
    int           nr;
    int           lat;
    int           wc;
    int           rc;
    bit           err;
    logic [127:0] data;
    int           gap;
  } cmd_t;

  logic         clk;
  logic         rst;
  logic         req_valid, req_ready, req_dirty, req_fill;
  logic [27:0]  req_wb_addr, req_fill_addr;
  logic [127:0] req_wb_data;
  logic         resp_valid, err_timeout;
  logic [127:0] resp_data;
  logic         mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  mem_line_master #(.ADDR_W(28), .LINE_W(128), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dirty(req_dirty), .req_fill(req_fill),
    .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
    .req_fill_addr(req_fill_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .err_timeout(err_timeout),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int n_tests = 0, n_fail = 0;
  int cyc = 0, scnt = 0;
  int lat_w = 0, lat_r = 0;
  bit noise = 0;
  logic [27:0]  exp_wa, exp_fa;
  logic [127:0] exp_wd, rdata_v;
  int wcyc, rcyc, resp_cnt, first_resp, acc_cyc, accepts;
  int overlap, bad, unstable, idle_run, gap, rdy_low;
  bit wr_seen, armed, prev_strobe = 0;
  logic [27:0]  prev_addr;
  logic [127:0] prev_wd;
  bit m_err;
  logic [127:0] m_data;

  task automatic chk_i(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    wcyc = 0; rcyc = 0; resp_cnt = 0; first_resp = -1; acc_cyc = -1;
    accepts = 0; overlap = 0; bad = 0; unstable = 0; idle_run = 0;
    gap = -1; rdy_low = 0; wr_seen = 0; armed = 0;
  endtask

  // One clock: observe at the falling edge, then play the memory.
  task automatic tick();
    bit acc, st;
    acc = req_valid && req_ready;
    @(negedge clk);
    cyc++;
    if (acc) begin
      accepts++;
      armed = 1;
      acc_cyc = cyc - 1;
    end
    st = mem_read || mem_write;
    if (mem_read && mem_write) overlap++;
    if (st) begin
      scnt++;
      if (prev_strobe && (mem_addr !== prev_addr || mem_wdata !== prev_wd))
        unstable++;
      if (!prev_strobe && mem_read && wr_seen) gap = idle_run;
      if (mem_write) begin
        wcyc++;
        wr_seen = 1;
        if (mem_addr !== exp_wa || mem_wdata !== exp_wd) bad++;
      end
      if (mem_read) begin
        rcyc++;
        if (mem_addr !== exp_fa) bad++;
      end
      idle_run = 0;
    end else begin
      scnt = 0;
      idle_run++;
    end
    if (resp_valid) begin
      resp_cnt++;
      if (first_resp < 0) first_resp = cyc;
    end
    if (armed && !req_ready) rdy_low++;
    prev_strobe = st;
    prev_addr = mem_addr;
    prev_wd = mem_wdata;
    if (st && scnt == (mem_write ? lat_w : lat_r)) begin
      mem_ready = 1'b1;
      mem_rdata = rdata_v;
    end else begin
      mem_ready = noise && !st && ($urandom_range(0, 3) == 0);
      mem_rdata = {4{$urandom}};
    end
  endtask

  task automatic scramble();
    req_dirty = 1'($urandom);
    req_fill = 1'($urandom);
    req_wb_addr = 28'($urandom);
    req_fill_addr = 28'($urandom);
    req_wb_data = {4{$urandom}};
  endtask

  function automatic cmd_t mk(bit d, bit f, logic [27:0] wa,
      logic [127:0] wd, logic [27:0] fa, logic [127:0] rd, int nw, int nr,
      int lat, int wc, int rc, bit err, logic [127:0] data, int gp);
    cmd_t c;
    c.dirty = d; c.fill = f; c.wa = wa; c.wd = wd; c.fa = fa; c.rd = rd;
    c.nw = nw; c.nr = nr; c.lat = lat; c.wc = wc; c.rc = rc;
    c.err = err; c.data = data; c.gap = gp;
    return c;
  endfunction

  // Outcome of a command from its memory latencies (0 or >MAXW: no ready).
  function automatic cmd_t model(input cmd_t c);
    bit to;
    to = 0;
    c.wc = 0; c.rc = 0; c.lat = 1; c.gap = -1;
    if (c.dirty) begin
      if (c.nw >= 1 && c.nw <= MAXW) c.wc = c.nw;
      else begin
        c.wc = MAXW;
        to = 1;
      end
      c.lat += c.wc + 1;
    end
    if (c.fill && !to) begin
      if (c.dirty) c.gap = 1;
      if (c.nr >= 1 && c.nr <= MAXW) begin
        c.rc = c.nr;
        m_data = c.rd;
      end else begin
        c.rc = MAXW;
        to = 1;
      end
      c.lat += c.rc + 1;
    end
    if (to) m_err = 1;
    c.err = m_err;
    c.data = m_data;
    return c;
  endfunction

  task automatic run_cmd(input cmd_t c, input bit hold, input string tag);
    int n;
    lat_w = c.nw; lat_r = c.nr; rdata_v = c.rd;
    exp_wa = c.wa; exp_wd = c.wd; exp_fa = c.fa;
    req_dirty = c.dirty; req_fill = c.fill;
    req_wb_addr = c.wa; req_wb_data = c.wd; req_fill_addr = c.fa;
    req_valid = 1'b1;
    clr();
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    tick();
    if (!hold) begin
      req_valid = 1'b0;
      scramble();
    end
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    chk_i({tag, " accepts"}, accepts, 1);
    chk_i({tag, " latency"}, first_resp - acc_cyc, c.lat);
    chk_i({tag, " resp_pulses"}, resp_cnt, 1);
    chk_i({tag, " write_cycles"}, wcyc, c.wc);
    chk_i({tag, " read_cycles"}, rcyc, c.rc);
    chk_d({tag, " resp_data"}, resp_data, c.data);
    chk_i({tag, " err_timeout"}, int'(err_timeout), int'(c.err));
    chk_i({tag, " strobe_rules"}, overlap + bad + unstable, 0);
    chk_i({tag, " ready_low"}, rdy_low, c.lat + 1);
    if (c.gap >= 0) chk_i({tag, " gap"}, gap, c.gap);
  endtask

  cmd_t tbl[10];
  cmd_t c;

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    req_dirty = 0; req_fill = 0; req_wb_addr = '0; req_wb_data = '0;
    req_fill_addr = '0; rdata_v = '0;
    exp_wa = '0; exp_wd = '0; exp_fa = '0;
    clr();
    tick(); tick();
    chk_i("reset req_ready", int'(req_ready), 1);
    chk_i("reset resp_valid", int'(resp_valid), 0);
    chk_d("reset resp_data", resp_data, '0);
    chk_i("reset err", int'(err_timeout), 0);
    chk_i("reset strobes", int'(mem_read) + int'(mem_write), 0);
    chk_d("reset mem_addr", {100'd0, mem_addr}, '0);
    chk_d("reset mem_wdata", mem_wdata, '0);
    rst = 1'b0;
    tick();

    tbl[0] = mk(0, 1, 28'h0, '0, 28'h0000010, D1, 0, 5,
                7, 0, 5, 0, D1, -1);
    tbl[1] = mk(1, 1, 28'h0000020, {16{8'hA5}}, 28'h0000030, D2, 3, 4,
                10, 3, 4, 0, D2, 1);
    tbl[2] = mk(0, 0, 28'h41, {16{8'h5A}}, 28'h42, D3, 2, 2,
                1, 0, 0, 0, D2, -1);
    tbl[3] = mk(0, 1, 28'h0, '0, 28'hFFFFFFF, D4, 0, 8,
                10, 0, 8, 0, D4, -1);
    tbl[4] = mk(1, 0, 28'h50, {8{16'h1234}}, 28'h51, D5, 1, 3,
                3, 1, 0, 0, D4, -1);
    tbl[5] = mk(0, 1, 28'h0, '0, 28'h60, D6, 0, 1,
                3, 0, 1, 0, D6, -1);
    tbl[6] = mk(0, 1, 28'h0, '0, 28'h70, D7, 0, 0,
                10, 0, 8, 1, D6, -1);
    tbl[7] = mk(0, 1, 28'h0, '0, 28'h80, D8, 0, 2,
                4, 0, 2, 1, D8, -1);
    tbl[8] = mk(1, 1, 28'h90, {16{8'h3C}}, 28'h91, D9, 0, 3,
                10, 8, 0, 1, D8, -1);
    tbl[9] = mk(1, 1, 28'hA0, {16{8'hC3}}, 28'hA1, D10, 8, 9,
                19, 8, 8, 1, D8, 1);
    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i], 0, $sformatf("tbl%0d", i));
    end
    m_err = 1;
    m_data = D8;

    // request held high through DONE: second command waits for ready
    c = model(mk(0, 0, 28'h11, D3, 28'h12, D3, 1, 1, 0, 0, 0, 0, '0, -1));
    run_cmd(c, 1, "b2b_first");
    c = model(mk(0, 1, 28'h13, D5, 28'h0000777, D5, 1, 3,
                 0, 0, 0, 0, '0, -1));
    run_cmd(c, 0, "b2b_second");

    // reset while a read is outstanding
    lat_r = 0; lat_w = 0; exp_fa = 28'h0ABCDEF;
    req_dirty = 0; req_fill = 1; req_fill_addr = 28'h0ABCDEF;
    req_valid = 1'b1;
    clr();
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!mem_read && n < 10) begin tick(); n++; end
    chk_i("rst_mid read_seen", int'(mem_read), 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_i("rst_mid strobes", int'(mem_read) + int'(mem_write), 0);
    chk_i("rst_mid req_ready", int'(req_ready), 1);
    chk_i("rst_mid err", int'(err_timeout), 0);
    chk_i("rst_mid resp_valid", int'(resp_valid), 0);
    chk_d("rst_mid resp_data", resp_data, '0);
    clr();
    repeat (12) tick();
    chk_i("rst_mid no_resp", resp_cnt, 0);
    chk_i("rst_mid no_strobe", wcyc + rcyc, 0);
    m_err = 0;
    m_data = '0;

    noise = 1;
    for (int i = 0; i < 40; i++) begin
      c.dirty = 1'($urandom);
      c.fill = 1'($urandom);
      c.wa = 28'($urandom);
      c.wd = {4{$urandom}};
      c.fa = 28'($urandom);
      c.rd = {4{$urandom}};
      c.nw = $urandom_range(0, MAXW + 1);
      c.nr = $urandom_range(0, MAXW + 1);
      c = model(c);
      run_cmd(c, 0, $sformatf("rnd%0d", i));
    end
    noise = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
